// File: rtl/student_sample_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | student_sample_writer_if                                                     |
// | DPRAM port A write bus plus FIR-engine frame request/acknowledge handshake.  |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
interface student_sample_writer_if #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16
);
  logic                 ena_o;
  logic                 wea_o;
  logic [AddrWidth-1:0] addra_o;
  logic [DataSize-1:0]  dia_o;
  logic                 frame_req_o;
  logic [AddrWidth-1:0] head_addr_o;
  logic                 frame_ack_i;

  modport master (
    output ena_o, wea_o, addra_o, dia_o, frame_req_o, head_addr_o,
    input  frame_ack_i
  );

  modport slave (
    input  ena_o, wea_o, addra_o, dia_o, frame_req_o, head_addr_o,
    output frame_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/student_sample_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | student_sample_writer                                                        |
// | Circular-buffer sample writer into DPRAM port A with FIR head-address        |
// | handshake. Optional STUDENT_SAMPLE_WRITER_DROP_CNT_EN adds drop_cnt_o.       |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module student_sample_writer #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16,
  parameter int Depth     = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_stb_i,
  student_sample_writer_if.master dp,
  output logic                 primed_o,
  output logic [AddrWidth:0]   fill_o,
  output logic                 overrun_o
`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt_o
`endif
);

  localparam logic [AddrWidth-1:0] LAST_ADDR = AddrWidth'(Depth - 1);
  localparam logic [AddrWidth:0]   FULL_FILL = (AddrWidth + 1)'(Depth);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_REQ   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] head_q, head_d;
  logic [AddrWidth-1:0] addra_q, addra_d;
  logic [DataSize-1:0]  dia_q, dia_d;
  logic                 ena_q, ena_d;
  logic [AddrWidth:0]   fill_q, fill_d;
  logic                 primed_q, primed_d;
  logic                 overrun_q, overrun_d;
  logic                 w_strobe;
  logic                 w_capture;
  logic                 w_drop;
`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
  logic [15:0]          drop_cnt_q, drop_cnt_d;
`endif

  assign w_strobe = sample_stb_i & enable_i;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    head_d    = head_q;
    addra_d   = addra_q;
    dia_d     = dia_q;
    ena_d     = 1'b0;
    fill_d    = fill_q;
    overrun_d = overrun_q;
    w_capture = 1'b0;
    w_drop    = 1'b0;

    if (clear_i) begin
      state_d   = ST_IDLE;
      wr_ptr_d  = '0;
      fill_d    = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: w_capture = w_strobe;
        ST_WRITE: begin
          head_d   = wr_ptr_q;
          wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
          if (fill_q != FULL_FILL) fill_d = fill_q + 1'b1;
          state_d  = ST_REQ;
          w_drop   = w_strobe;
        end
        ST_REQ: begin
          if (dp.frame_ack_i) begin
            state_d   = ST_IDLE;
            w_capture = w_strobe;
          end else begin
            w_drop = w_strobe;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Capture registers the write address and data so port A holds them afterwards.
      if (w_capture) begin
        state_d = ST_WRITE;
        ena_d   = 1'b1;
        addra_d = wr_ptr_q;
        dia_d   = sample_i;
      end
      if (w_drop) overrun_d = 1'b1;
    end

    primed_d = (fill_d == FULL_FILL);
  end

`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_i) drop_cnt_d = '0;
    else if (w_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      head_q    <= '0;
      addra_q   <= '0;
      dia_q     <= '0;
      ena_q     <= 1'b0;
      fill_q    <= '0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      head_q    <= head_d;
      addra_q   <= addra_d;
      dia_q     <= dia_d;
      ena_q     <= ena_d;
      fill_q    <= fill_d;
      primed_q  <= primed_d;
      overrun_q <= overrun_d;
    end
  end

  assign dp.ena_o       = ena_q;
  assign dp.wea_o       = ena_q;
  assign dp.addra_o     = addra_q;
  assign dp.dia_o       = dia_q;
  assign dp.frame_req_o = (state_q == ST_REQ);
  assign dp.head_addr_o = head_q;
  assign fill_o         = fill_q;
  assign primed_o       = primed_q;
  assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_student_sample_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_student_sample_writer                                                     |
// | Directed stimulus with queue scoreboard for student_sample_writer (Depth=4). |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module tb_student_sample_writer;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          clear;
  logic [DW-1:0] sample;
  logic          stb;
  logic          primed;
  logic [AW:0]   fill;
  logic          overrun;
`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  student_sample_writer_if #(.AddrWidth(AW), .DataSize(DW)) dp_if ();

  student_sample_writer #(.AddrWidth(AW), .DataSize(DW), .Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .clear_i      (clear),
    .sample_i     (sample),
    .sample_stb_i (stb),
    .dp           (dp_if.master),
    .primed_o     (primed),
    .fill_o       (fill),
    .overrun_o    (overrun)
`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
    ,
    .drop_cnt_o   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0]    rq[$];
  logic [AW-1:0]    exp_ptr  = '0;
  int               exp_fill = 0;
  logic             prev_req = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every port-A write and on each new request.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n) begin
      if (dp_if.wea_o) begin
        if (wq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   dp_if.addra_o, dp_if.dia_o);
        end else begin
          e = wq.pop_front();
          check("write_addr", 32'(dp_if.addra_o), 32'(e[AW+DW-1:DW]));
          check("write_data", 32'(dp_if.dia_o), 32'(e[DW-1:0]));
          check("write_ena", 32'(dp_if.ena_o), 32'd1);
        end
      end
      if (dp_if.frame_req_o && !prev_req) begin
        if (rq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got head %0h expected no request", dp_if.head_addr_o);
        end else begin
          check("req_head", 32'(dp_if.head_addr_o), 32'(rq.pop_front()));
        end
      end
      prev_req = dp_if.frame_req_o;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [DW-1:0] d);
    wq.push_back({exp_ptr, d});
    rq.push_back(exp_ptr);
    exp_ptr  = (exp_ptr == AW'(DEPTH - 1)) ? '0 : exp_ptr + 1'b1;
    exp_fill = (exp_fill < DEPTH) ? exp_fill + 1 : DEPTH;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!dp_if.frame_req_o && k < 8) begin
      tick();
      k++;
    end
    check("req_timeout", 32'(dp_if.frame_req_o), 32'd1);
  endtask

  // Strobe one sample, verify the 1-cycle write / 2-cycle request latency.
  task automatic send(input logic [DW-1:0] d);
    push_expect(d);
    sample = d;
    stb    = 1'b1;
    tick();
    stb = 1'b0;
    check("lat_write", 32'(dp_if.wea_o), 32'd1);
    tick();
    check("lat_req", 32'(dp_if.frame_req_o), 32'd1);
    wait_req();
  endtask

  task automatic ack();
    dp_if.frame_ack_i = 1'b1;
    tick();
    dp_if.frame_ack_i = 1'b0;
    tick();
    check("req_dropped", 32'(dp_if.frame_req_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    sample = '0;
    stb = 1'b0;
    dp_if.frame_ack_i = 1'b0;
    repeat (3) tick();
    check("rst_ena", 32'(dp_if.ena_o), 32'd0);
    check("rst_wea", 32'(dp_if.wea_o), 32'd0);
    check("rst_req", 32'(dp_if.frame_req_o), 32'd0);
    check("rst_addra", 32'(dp_if.addra_o), 32'd0);
    check("rst_dia", 32'(dp_if.dia_o), 32'd0);
    check("rst_head", 32'(dp_if.head_addr_o), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // First sample plus four more: addresses 0,1,2,3,0 and fill saturating at 4.
    send(16'h1234);
    repeat (2) tick();
    check("req_held", 32'(dp_if.frame_req_o), 32'd1);
    ack();
    check("fill_1", 32'(fill), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(16'h0001 + DW'(i));
      ack();
      check("fill_sat", 32'(fill), 32'(exp_fill));
      check("primed", 32'(primed), (exp_fill == DEPTH) ? 32'd1 : 32'd0);
    end

    // Strobe during REQ without ack is dropped.
    send(16'hAAAA);
    sample = 16'hBBBB;
    stb = 1'b1;
    tick();
    stb = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    check("req_kept", 32'(dp_if.frame_req_o), 32'd1);
`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif
    ack();
    send(16'hCCCC);
    ack();
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Clear in the middle of a request.
    send(16'hDDDD);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_req", 32'(dp_if.frame_req_o), 32'd0);
    check("clr_fill", 32'(fill), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_primed", 32'(primed), 32'd0);
`ifdef STUDENT_SAMPLE_WRITER_DROP_CNT_EN
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    exp_ptr = '0;
    exp_fill = 0;
    send(16'hEEEE);
    ack();

    // Ack and next strobe together: written next cycle at the following address.
    send(16'h0F0F);
    push_expect(16'h5A5A);
    sample = 16'h5A5A;
    stb = 1'b1;
    dp_if.frame_ack_i = 1'b1;
    tick();
    stb = 1'b0;
    dp_if.frame_ack_i = 1'b0;
    check("ackstb_write", 32'(dp_if.wea_o), 32'd1);
    wait_req();
    ack();
    check("ackstb_overrun", 32'(overrun), 32'd0);
    check("ackstb_fill", 32'(fill), 32'(exp_fill));

    // Strobes with enable low are ignored.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample = 16'h7000 + DW'(i);
      stb = 1'b1;
      tick();
      stb = 1'b0;
      tick();
    end
    repeat (3) tick();
    check("dis_overrun", 32'(overrun), 32'd0);
    check("dis_fill", 32'(fill), 32'(exp_fill));
    check("dis_req", 32'(dp_if.frame_req_o), 32'd0);
    enable = 1'b1;

    repeat (3) tick();
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
